// File: rtl/key_scan_if.sv
// Board key interface: scan control, serial chain pins and debounced key state.
interface key_scan_if;
    logic        en;
    logic        sdi;
    logic        sclk;
    logic        ld_n;
    logic [15:0] dip;
    logic [4:0]  push;
    logic [4:0]  push_press;
    logic        frame_valid;
    logic        busy;

    modport slave (
        input  en,
        input  sdi,
        output sclk,
        output ld_n,
        output dip,
        output push,
        output push_press,
        output frame_valid,
        output busy
    );

    modport master (
        output en,
        output sdi,
        input  sclk,
        input  ld_n,
        input  dip,
        input  push,
        input  push_press,
        input  frame_valid,
        input  busy
    );
endinterface

// File: rtl/key_scan_ctrl.sv
// Scans a PISO DIP/push-button chain, deserialises each frame and publishes
// frame-debounced dip/push state with per-button press pulses.
module key_scan_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int NBITS      = 22,
    parameter int SCAN_GAP   = 1000,
    parameter int DEB_FRAMES = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    key_scan_if.slave bus
);

    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(NBITS);
    localparam int STB_W = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(SCAN_GAP - 1);
    localparam logic [DIV_W-1:0] LOAD_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(DEB_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [GAP_W-1:0] r_gap;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic             r_high;
    // The frame's top bit is unused, so it simply falls off the end of the shifter.
    logic [NBITS-2:0] r_sr;
    logic [20:0]      r_cand;
    logic [STB_W-1:0] r_stable;

    logic             r_sclk;
    logic             r_ld_n;
    logic [15:0]      r_dip;
    logic [4:0]       r_push;
    logic [4:0]       r_press;
    logic             r_fv;
    logic             r_busy;

    logic [20:0]      w_frame;
    logic             w_match;
    logic [STB_W-1:0] w_stable_nxt;
    logic             w_commit;

    // Push buttons are active-low on the wire; flip them so 1 = pressed.
    assign w_frame = {~r_sr[20:16], r_sr[15:0]};
    assign w_match = (w_frame == r_cand);

    always_comb begin
        w_stable_nxt = '0;
        if (w_match) begin
            if (r_stable == STB_LAST) begin
                w_stable_nxt = r_stable;
            end else begin
                w_stable_nxt = r_stable + 1'b1;
            end
        end
    end

    assign w_commit = (w_stable_nxt == STB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gap    <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_high   <= 1'b0;
            r_sr     <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_sclk   <= 1'b0;
            r_ld_n   <= 1'b1;
            r_dip    <= '0;
            r_push   <= '0;
            r_press  <= '0;
            r_fv     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_fv    <= 1'b0;
            r_press <= '0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.en) begin
                        r_gap <= '0;
                    end else if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_div   <= '0;
                        r_ld_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                S_LOAD: begin
                    if (r_div == LOAD_LAST) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_high  <= 1'b0;
                        r_ld_n  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_div != HALF_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else if (!r_high) begin
                        // End of the low half: the chain output has settled, capture it.
                        r_div  <= '0;
                        r_sr   <= {r_sr[NBITS-3:0], bus.sdi};
                        r_sclk <= 1'b1;
                        r_high <= 1'b1;
                    end else begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        r_high <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_fv     <= 1'b1;
                    r_stable <= w_stable_nxt;
                    if (!w_match) begin
                        r_cand <= w_frame;
                    end
                    // On a commit the new candidate always equals this frame.
                    if (w_commit) begin
                        r_dip   <= w_frame[15:0];
                        r_push  <= w_frame[20:16];
                        r_press <= w_frame[20:16] & ~r_push;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sclk        = r_sclk;
    assign bus.ld_n        = r_ld_n;
    assign bus.dip         = r_dip;
    assign bus.push        = r_push;
    assign bus.push_press  = r_press;
    assign bus.frame_valid = r_fv;
    assign bus.busy        = r_busy;

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
- Sequences an external parallel-in/serial-out switch chain (16 DIP switches plus 5 active-low push buttons, 22-bit frame) for the board key interface.
- Generates the chain's load strobe and shift clock, and deserialises the returned bit stream.
- Debounces whole frames and publishes stable dip/push state plus per-button press pulses to the rest of the design.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- NBITS, 22, bits per frame. Layout: [15:0] dip, [20:16] push (active-low on wire), [21] unused.
- SCAN_GAP, 1000, idle clk cycles between frames (>=1).
- DEB_FRAMES, 3, consecutive identical frames required before outputs update (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scanning enable
- sdi  in  1  serial data from chain
- sclk  out  1  shift clock to chain
- ld_n  out  1  active-low parallel-load strobe to chain
- dip  out  16  debounced DIP state
- push  out  5  debounced button state, 1 = pressed (inverted from wire)
- push_press  out  5  one-cycle pulse per button on debounced 0->1
- frame_valid  out  1  one-cycle pulse after every completed frame
- busy  out  1  high in LOAD/SHIFT/DONE

Behaviour:
- Reset (async, rst_n low): sclk=0, ld_n=1, dip=0, push=0, push_press=0, frame_valid=0, busy=0. FSM goes to IDLE with gap counter 0, candidate frame 0 and stable count 0. Reset mid-frame aborts the frame; no outputs change.
- IDLE: gap counter increments each cycle while en=1 and holds at 0 while en=0. When it reaches SCAN_GAP-1, go to LOAD and clear the counter.
- LOAD: ld_n=0 for exactly 2*CLK_DIV cycles with sclk=0, then go to SHIFT with bit index 0.
- SHIFT, per bit:
  - Low phase: sclk=0 for CLK_DIV cycles. sdi is sampled on the last cycle of the low phase into shift register sr <= {sr[NBITS-2:0], sdi}, so the first bit sampled ends up as frame bit 21.
  - High phase: sclk=1 for CLK_DIV cycles.
  - After the high phase of bit NBITS-1, go to DONE with sclk=0.
  - One frame therefore takes 2*CLK_DIV + 2*CLK_DIV*NBITS + 1 cycles from LOAD entry through DONE.
- DONE (1 cycle): form f = {sr[21], ~sr[20:16], sr[15:0]} (wire-level push bits inverted, so 1 = pressed).
  - If f[20:0] == cand: stable_cnt <= min(stable_cnt+1, DEB_FRAMES-1).
  - Otherwise: cand <= f[20:0] and stable_cnt <= 0.
  - Commit when the stable_cnt value after this update equals DEB_FRAMES-1 (with DEB_FRAMES=1, every frame commits): dip <= cand[15:0], push <= cand[20:16], registered on the cycle after DONE.
  - push_press[i] = 1 for that single cycle iff the new push[i]=1 and the old push[i]=0.
  - frame_valid pulses on the same cycle as the commit, or on the cycle after DONE when no commit occurs.
  - Return to IDLE.
- en deassertion during LOAD/SHIFT/DONE does not abort: the frame completes, then the FSM holds in IDLE.
- Bit 21 is ignored by the compare and never reaches any output.
- sclk and ld_n are registered outputs and glitch-free. ld_n=0 and sclk=1 never occur together.

Test Plan:
- Reset and idle (CLK_DIV=1, SCAN_GAP=4, DEB_FRAMES=2): hold rst_n=0 -> all outputs 0, ld_n=1. Release with en=0 for 100 cycles -> no ld_n pulse.
- Single frame timing (same parameters, en=1): first ld_n low 4 cycles after reset release, lasting 2 cycles. Then 22 sclk pulses of 1 low/1 high cycle. frame_valid arrives 47 cycles after LOAD entry.
- Data mapping: chain drives frame 0x1EA5C3 (push wire bits 0b11110 = button 0 pressed) for 2 frames -> dip=0xA5C3, push=5'b00001, push_press=5'b00001 pulsed once. A third identical frame gives no further push_press.
- Debounce rejection (DEB_FRAMES=3): frames A, B, A, A, A with A=dip 0x0001 -> outputs update only after the 5th frame. Frames A, B, A alone -> outputs unchanged.
- Release/press: buttons 0->released and 4->pressed in one stable transition -> push=5'b10000, push_press=5'b10000 only.
- Mid-operation: deassert en mid-SHIFT -> frame completes and frame_valid pulses, then no new LOAD. Pulse rst_n low mid-SHIFT -> sclk=0 and ld_n=1 immediately, dip/push=0, next frame starts SCAN_GAP cycles after release.
